// File: rtl/invaders_pkg.sv
// Shared constants for the invaders game blocks: screen geometry, default
// alien formation geometry and the bullet-pool controller state encoding.
package invaders_pkg;

  localparam int SCREEN_H      = 480;
  localparam int OFFSCREEN_ROW = 500;

  localparam int DEF_ALIEN_W = 30;
  localparam int DEF_ALIEN_H = 20;
  localparam int DEF_SPACE_W = 10;
  localparam int DEF_SPACE_H = 10;

  // Controller states: wait for a tick, advance all bullets, scan one slot per cycle
  typedef logic [1:0] pool_state_t;
  localparam pool_state_t ST_IDLE = 2'd0;
  localparam pool_state_t ST_MOVE = 2'd1;
  localparam pool_state_t ST_SCAN = 2'd2;

  // Index width that stays legal for single-entry ranges
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bullet_hit_calc.sv
// Combinational bullet-vs-formation test. Finds the grid cell under the
// bullet with unrolled constant compares (no divider) and reports whether
// the bullet lies inside that alien's body rather than in a gap.
module bullet_hit_calc
  import invaders_pkg::*;
#(
  parameter int GRID_COLS = 10,
  parameter int GRID_ROWS = 5,
  parameter int ALIEN_W   = DEF_ALIEN_W,
  parameter int ALIEN_H   = DEF_ALIEN_H,
  parameter int SPACE_W   = DEF_SPACE_W,
  parameter int SPACE_H   = DEF_SPACE_H,
  parameter int ROW_W     = 9,
  parameter int COL_W     = 10,
  parameter int IDX_W     = 6
) (
  input  logic [ROW_W-1:0] row,
  input  logic [COL_W-1:0] col,
  input  logic [ROW_W-1:0] aliens_row,
  input  logic [COL_W-1:0] aliens_col,
  output logic             hit_candidate,
  output logic [IDX_W-1:0] cell_index
);

  localparam int PITCH_W = ALIEN_W + SPACE_W;
  localparam int PITCH_H = ALIEN_H + SPACE_H;

  logic [COL_W-1:0] dx_s;
  logic [COL_W-1:0] dy_s;
  logic [COL_W-1:0] base_x_s;
  logic [COL_W-1:0] base_y_s;
  logic [COL_W-1:0] off_x_s;
  logic [COL_W-1:0] off_y_s;
  int               c_s;
  int               r_s;

  // Locate the cell: thresholds are monotonic, so the last passing compare wins
  always_comb begin
    dx_s     = col - aliens_col;
    dy_s     = COL_W'(row) - COL_W'(aliens_row);
    c_s      = 0;
    r_s      = 0;
    base_x_s = '0;
    base_y_s = '0;
    for (int k = 1; k < GRID_COLS; k++) begin
      c_s      = (dx_s >= COL_W'(k * PITCH_W)) ? k : c_s;
      base_x_s = (dx_s >= COL_W'(k * PITCH_W)) ? COL_W'(k * PITCH_W) : base_x_s;
    end
    for (int k = 1; k < GRID_ROWS; k++) begin
      r_s      = (dy_s >= COL_W'(k * PITCH_H)) ? k : r_s;
      base_y_s = (dy_s >= COL_W'(k * PITCH_H)) ? COL_W'(k * PITCH_H) : base_y_s;
    end
    off_x_s       = dx_s - base_x_s;
    off_y_s       = dy_s - base_y_s;
    cell_index    = IDX_W'(r_s * GRID_COLS + c_s);
    hit_candidate = (col >= aliens_col) && (row >= aliens_row) &&
                    (off_x_s < COL_W'(ALIEN_W)) && (off_y_s < COL_W'(ALIEN_H)) &&
                    (dx_s < COL_W'(GRID_COLS * PITCH_W)) &&
                    (dy_s < COL_W'(GRID_ROWS * PITCH_H));
  end

endmodule

// File: rtl/bullet_pool.sv
// Multi-slot player bullet manager. Spawns bullets on fire requests with a
// cooldown, advances them once per Move_Tick and scans one slot per cycle
// against the alien alive-grid, which this block owns.
// Optional: define BULLET_POOL_SCORE_EN to add a saturating 16-bit Score output.
module bullet_pool
  import invaders_pkg::*;
#(
  parameter int NUM_BULLETS   = 4,
  parameter int GRID_COLS     = 10,
  parameter int GRID_ROWS     = 5,
  parameter int ALIEN_W       = DEF_ALIEN_W,
  parameter int ALIEN_H       = DEF_ALIEN_H,
  parameter int SPACE_W       = DEF_SPACE_W,
  parameter int SPACE_H       = DEF_SPACE_H,
  parameter int BULLET_STEP   = 10,
  parameter int FIRE_COOLDOWN = 8,
  parameter int ROW_W         = 9,
  parameter int COL_W         = 10
) (
  input  logic                              Clk,
  input  logic                              Reset,
  input  logic                              Move_Tick,
  input  logic                              Bullet_Fired,
  input  logic [ROW_W-1:0]                  Aliens_Row,
  input  logic [COL_W-1:0]                  Aliens_Col,
  input  logic [ROW_W-1:0]                  Player_Row,
  input  logic [COL_W-1:0]                  Player_Col,
  output logic [NUM_BULLETS*ROW_W-1:0]      Bullet_Row,
  output logic [NUM_BULLETS*COL_W-1:0]      Bullet_Col,
  output logic [NUM_BULLETS-1:0]            Bullet_Active,
  output logic [GRID_COLS*GRID_ROWS-1:0]    Aliens_Grid,
  output logic                              Hit_Pulse,
  output logic [$clog2(GRID_COLS*GRID_ROWS)-1:0] Hit_Index,
  output logic                              Aliens_Defeated,
  output logic                              Busy
`ifdef BULLET_POOL_SCORE_EN
  ,
  output logic [15:0]                       Score
`endif
);

  localparam int NCELLS = GRID_COLS * GRID_ROWS;
  localparam int IDX_W  = $clog2(NCELLS);
  localparam int SLOT_W = idx_width(NUM_BULLETS);
  localparam int COOL_W = idx_width(FIRE_COOLDOWN + 1);
  localparam logic [ROW_W-1:0] OFF_ROW = ROW_W'(OFFSCREEN_ROW);

  pool_state_t          state_r;
  logic [SLOT_W-1:0]    slot_r;
  logic [COOL_W-1:0]    cooldown_r;
  logic                 pending_r;
  logic [NCELLS-1:0]    grid_r;
  logic [NUM_BULLETS-1:0] active_r;
  logic [ROW_W-1:0]     row_r [NUM_BULLETS];
  logic [COL_W-1:0]     col_r [NUM_BULLETS];
  logic                 hit_pulse_r;
  logic [IDX_W-1:0]     hit_index_r;

  logic                 free_found_s;
  logic [SLOT_W-1:0]    free_idx_s;
  logic                 hit_s;
  logic [IDX_W-1:0]     cell_s;
  logic                 kill_s;

  bullet_hit_calc #(
    .GRID_COLS (GRID_COLS),
    .GRID_ROWS (GRID_ROWS),
    .ALIEN_W   (ALIEN_W),
    .ALIEN_H   (ALIEN_H),
    .SPACE_W   (SPACE_W),
    .SPACE_H   (SPACE_H),
    .ROW_W     (ROW_W),
    .COL_W     (COL_W),
    .IDX_W     (IDX_W)
  ) u_hit_calc (
    .row           (row_r[slot_r]),
    .col           (col_r[slot_r]),
    .aliens_row    (Aliens_Row),
    .aliens_col    (Aliens_Col),
    .hit_candidate (hit_s),
    .cell_index    (cell_s)
  );

  // Lowest-index free slot: walk downwards so the lowest free slot is written last
  always_comb begin
    free_found_s = 1'b0;
    free_idx_s   = '0;
    for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
      free_idx_s   = active_r[i] ? free_idx_s : SLOT_W'(i);
      free_found_s = free_found_s | ~active_r[i];
    end
  end

  // A kill needs the scanned slot live, inside an alien body, and that alien still alive
  always_comb begin
    kill_s = (state_r == ST_SCAN) && active_r[slot_r] && hit_s && grid_r[cell_s];
  end

  // Controller: spawn in IDLE, advance in MOVE, per-slot collision in SCAN
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r     <= ST_IDLE;
      slot_r      <= '0;
      cooldown_r  <= '0;
      pending_r   <= 1'b0;
      grid_r      <= '1;
      active_r    <= '0;
      hit_pulse_r <= 1'b0;
      hit_index_r <= '0;
      for (int i = 0; i < NUM_BULLETS; i++) begin
        row_r[i] <= OFF_ROW;
        col_r[i] <= '0;
      end
    end else begin
      hit_pulse_r <= 1'b0;
      if (Bullet_Fired) begin
        pending_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE: begin
          if (pending_r) begin
            // Request is consumed either way; a blocked fire is dropped, not queued
            pending_r <= Bullet_Fired;
            if ((cooldown_r == '0) && free_found_s) begin
              active_r[free_idx_s] <= 1'b1;
              row_r[free_idx_s]    <= Player_Row;
              col_r[free_idx_s]    <= Player_Col;
              cooldown_r           <= COOL_W'(FIRE_COOLDOWN);
            end
          end
          if (Move_Tick) begin
            state_r <= ST_MOVE;
          end
        end
        ST_MOVE: begin
          if (cooldown_r != '0) begin
            cooldown_r <= cooldown_r - COOL_W'(1);
          end
          for (int i = 0; i < NUM_BULLETS; i++) begin
            if (active_r[i]) begin
              if (row_r[i] >= ROW_W'(BULLET_STEP)) begin
                row_r[i] <= row_r[i] - ROW_W'(BULLET_STEP);
              end else begin
                active_r[i] <= 1'b0;
                row_r[i]    <= OFF_ROW;
              end
            end
          end
          slot_r  <= '0;
          state_r <= ST_SCAN;
        end
        ST_SCAN: begin
          if (kill_s) begin
            grid_r[cell_s]   <= 1'b0;
            active_r[slot_r] <= 1'b0;
            row_r[slot_r]    <= OFF_ROW;
            hit_pulse_r      <= 1'b1;
            hit_index_r      <= cell_s;
          end
          if (slot_r == SLOT_W'(NUM_BULLETS - 1)) begin
            state_r <= ST_IDLE;
          end else begin
            slot_r <= slot_r + SLOT_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef BULLET_POOL_SCORE_EN
  logic [15:0] score_r;

  // Score counts kills, holding at full scale
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_r <= 16'd0;
    end else if (kill_s && (score_r != 16'hFFFF)) begin
      score_r <= score_r + 16'd1;
    end
  end

  assign Score = score_r;
`endif

  for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_pack
    assign Bullet_Row[g*ROW_W +: ROW_W] = row_r[g];
    assign Bullet_Col[g*COL_W +: COL_W] = col_r[g];
  end

  assign Bullet_Active   = active_r;
  assign Aliens_Grid     = grid_r;
  assign Hit_Pulse       = hit_pulse_r;
  assign Hit_Index       = hit_index_r;
  assign Aliens_Defeated = (grid_r == '0);
  assign Busy            = (state_r != ST_IDLE);

endmodule
